// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding,
// row drive patterns and default timing parameters.
package keypad_pkg;

    localparam int unsigned SCAN_BITS_DEF    = 14;
    localparam int unsigned DEB_TICKS_DEF    = 8;
    localparam int unsigned REPEAT_TICKS_DEF = 256;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    localparam logic [3:0] ROW0_DRIVE = 4'b1110;
    localparam logic [3:0] ROW1_DRIVE = 4'b1101;
    localparam logic [3:0] ROW2_DRIVE = 4'b1011;
    localparam logic [3:0] ROW3_DRIVE = 4'b0111;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return ROW0_DRIVE;
            2'd1:    return ROW1_DRIVE;
            2'd2:    return ROW2_DRIVE;
            default: return ROW3_DRIVE;
        endcase
    endfunction

    // Lowest-index active-low column; caller guarantees at least one is low.
    function automatic logic [1:0] low_col(input logic [3:0] cols);
        if (!cols[0]) return 2'd0;
        if (!cols[1]) return 2'd1;
        if (!cols[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad columns.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_col,
    output logic [3:0] o_col
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= i_col;
            r_sync <= r_meta;
        end
    end

    assign o_col = r_sync;

endmodule

// File: rtl/keypad_scan_mux.sv
// 4x4 keypad scanner with tick-based debounce and an acknowledged key output.
// Define KEYPAD_SCAN_REPEAT_EN to auto-repeat a held key every REPEAT_TICKS ticks.
module keypad_scan_mux
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_BITS    = SCAN_BITS_DEF,
    parameter int unsigned DEB_TICKS    = DEB_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);

    logic [3:0]           w_col;
    logic                 w_tick;
    logic                 w_all_high;
    logic                 w_match;
    logic                 w_accept;
    logic [1:0]           w_row_next;

    state_e               r_state;
    logic [SCAN_BITS-1:0] r_presc;
    logic [1:0]           r_row;
    logic [1:0]           r_col_idx;
    logic [3:0]           r_pat;
    logic [DEB_W-1:0]     r_deb_cnt;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0]     r_rep_cnt;
`endif

    keypad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_col (col_in),
        .o_col (w_col)
    );

    assign w_tick     = &r_presc;
    assign w_all_high = &w_col;
    assign w_match    = (w_col == r_pat);
    assign w_row_next = r_row + 2'd1;

    // A key event: debounce completes, or (optionally) a held key hits its repeat interval.
    always_comb begin
        w_accept = 1'b0;
        if (w_tick) begin
            if (r_state == ST_DEBOUNCE)
                w_accept = w_match && (r_deb_cnt == DEB_W'(DEB_TICKS - 1));
`ifdef KEYPAD_SCAN_REPEAT_EN
            else if (r_state == ST_HELD)
                w_accept = !w_all_high && (r_rep_cnt == REP_W'(REPEAT_TICKS - 1));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_presc   <= '0;
            r_row     <= 2'd0;
            row_out   <= ROW0_DRIVE;
            r_col_idx <= 2'd0;
            r_pat     <= 4'b1111;
            r_deb_cnt <= '0;
            key_down  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            r_rep_cnt <= '0;
`endif
        end else begin
            r_presc <= r_presc + SCAN_BITS'(1);
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_all_high) begin
                            r_row   <= w_row_next;
                            row_out <= row_drive(w_row_next);
                        end else begin
                            r_pat     <= w_col;
                            r_col_idx <= low_col(w_col);
                            r_deb_cnt <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!w_match) begin
                            r_row   <= w_row_next;
                            row_out <= row_drive(w_row_next);
                            r_state <= ST_SCAN;
                        end else if (w_accept) begin
                            key_down  <= 1'b1;
                            r_deb_cnt <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                            r_rep_cnt <= '0;
`endif
                            r_state   <= ST_HELD;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                        end
                    end
                    ST_HELD: begin
                        // r_deb_cnt counts consecutive released ticks here
                        if (w_all_high) begin
`ifdef KEYPAD_SCAN_REPEAT_EN
                            r_rep_cnt <= '0;
`endif
                            if (r_deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
                                key_down  <= 1'b0;
                                r_deb_cnt <= '0;
                                r_row     <= w_row_next;
                                row_out   <= row_drive(w_row_next);
                                r_state   <= ST_SCAN;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            r_deb_cnt <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                            r_rep_cnt <= w_accept ? '0 : r_rep_cnt + REP_W'(1);
`endif
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    // Consumer handshake: a new key loads only into a free or just-acked slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_code  <= 4'b0000;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= {r_row, r_col_idx};
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_mux.sv
// Bench for keypad_scan_mux: a keypad matrix model, directed timing checks and
// randomized key presses checked through an expected-key scoreboard.
module tb_keypad_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_down;
    logic        overrun;

    logic        mon_ack = 1'b0;
    logic        dir_ack = 1'b0;
    logic        mon_en  = 1'b0;
    logic [15:0] pressed = 16'h0000;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          evt_count = 0;
    int          ov_count  = 0;
    logic [3:0]  exp_q[$];

    keypad_scan_mux #(
        .SCAN_BITS    (2),
        .DEB_TICKS    (3),
        .REPEAT_TICKS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    assign key_ack = mon_ack | dir_ack;

    // Switch matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    function automatic logic [3:0] drv(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Consumer + scoreboard: every presented key is compared and acked.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && key_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key: got %0h, expected none at %0t", key_code, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    chk("key_event_code", 8'(key_code), 8'(e));
                end
                evt_count++;
                mon_ack = 1'b1;
            end else begin
                mon_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (overrun === 1'b1) ov_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Returns on the first negedge where row r has just started being driven.
    task automatic wait_row_start(input int r);
        logic [3:0] prev;
        bit         found;
        prev  = row_out;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (row_out == drv(r) && prev != drv(r)) found = 1;
            prev = row_out;
        end
        chk("row_start_seen", 8'(found), 8'd1);
    endtask

    task automatic wait_evt(input int since);
        bit seen;
        seen = 0;
        for (int k = 0; k < 150 && !seen; k++) begin
            @(negedge clk);
            if (evt_count != since) seen = 1;
        end
        chk("key_event_seen", 8'(seen), 8'd1);
    endtask

    int r, c, n, d, gi, ev_start, exp_evts;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_row_out", 8'(row_out), 8'(4'b1110));
        chk("reset_key_valid", 8'(key_valid), 8'd0);
        chk("reset_key_code", 8'(key_code), 8'd0);
        chk("reset_key_down", 8'(key_down), 8'd0);
        chk("reset_overrun", 8'(overrun), 8'd0);
        reset = 1'b0;

        // Idle scan: four-cycle dwell per row, rows 0..3 then wrap.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("idle_row_out", 8'(row_out), 8'(drv((k / 4) % 4)));
            chk("idle_key_valid", 8'(key_valid), 8'd0);
        end

        // Key at row 2 / column 2 accepted after detect plus three matching ticks.
        wait_row_start(2);
        pressed[2*4+2] = 1'b1;
        repeat (15) @(negedge clk);
        chk("pre_accept_valid", 8'(key_valid), 8'd0);
        @(negedge clk);
        chk("accept_valid", 8'(key_valid), 8'd1);
        chk("accept_code", 8'(key_code), 8'hA);
        chk("accept_key_down", 8'(key_down), 8'd1);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        chk("ack_clears_valid", 8'(key_valid), 8'd0);
        chk("held_row_frozen", 8'(row_out), 8'(drv(2)));
        pressed = '0;
        repeat (40) @(negedge clk);
        chk("release_key_down", 8'(key_down), 8'd0);

        // Bounce during debounce: row freezes, then scanning resumes on the next row.
        for (int rb = 1; rb <= 2; rb++) begin
            wait_row_start(rb);
            pressed[rb*4+0] = 1'b1;
            repeat (4) @(negedge clk);
            chk("bounce_row_frozen", 8'(row_out), 8'(drv(rb)));
            pressed = '0;
            repeat (4) @(negedge clk);
            chk("bounce_row_advance", 8'(row_out), 8'(drv((rb + 1) % 4)));
            chk("bounce_valid", 8'(key_valid), 8'd0);
            chk("bounce_key_down", 8'(key_down), 8'd0);
        end

        // Unacked 0x5 then 0xC: overrun, old code kept.
        wait_row_start(1);
        pressed[1*4+1] = 1'b1;
        repeat (16) @(negedge clk);
        chk("first_valid", 8'(key_valid), 8'd1);
        chk("first_code", 8'(key_code), 8'h5);
        pressed = '0;
        repeat (40) @(negedge clk);
        wait_row_start(3);
        pressed[3*4+0] = 1'b1;
        repeat (16) @(negedge clk);
        chk("overrun_pulse", 8'(overrun), 8'd1);
        chk("overrun_code_kept", 8'(key_code), 8'h5);
        chk("overrun_valid", 8'(key_valid), 8'd1);
        chk("overrun_key_down", 8'(key_down), 8'd1);
        @(negedge clk);
        chk("overrun_one_cycle", 8'(overrun), 8'd0);
        pressed = '0;
        repeat (40) @(negedge clk);

        // Ack coinciding with acceptance: new code loads, no overrun.
        wait_row_start(3);
        pressed[3*4+0] = 1'b1;
        repeat (15) @(negedge clk);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        chk("ack_accept_code", 8'(key_code), 8'hC);
        chk("ack_accept_valid", 8'(key_valid), 8'd1);
        chk("ack_accept_overrun", 8'(overrun), 8'd0);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        chk("ack_clear_valid", 8'(key_valid), 8'd0);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        chk("ack_idle_ignored", 8'(key_valid), 8'd0);
        pressed = '0;
        repeat (40) @(negedge clk);

        // Reset mid-debounce with a pending key.
        wait_row_start(0);
        pressed[0*4+1] = 1'b1;
        repeat (16) @(negedge clk);
        chk("pending_valid", 8'(key_valid), 8'd1);
        chk("pending_code", 8'(key_code), 8'h1);
        pressed = '0;
        repeat (40) @(negedge clk);
        wait_row_start(2);
        pressed[2*4+2] = 1'b1;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_row_out", 8'(row_out), 8'(4'b1110));
        chk("midrst_valid", 8'(key_valid), 8'd0);
        chk("midrst_code", 8'(key_code), 8'd0);
        chk("midrst_key_down", 8'(key_down), 8'd0);
        chk("midrst_overrun", 8'(overrun), 8'd0);
        pressed = '0;
        reset   = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_valid", 8'(key_valid), 8'd0);

        mon_en = 1'b1;

        // Hold 0x3 for twelve ticks past acceptance; repeats only with the macro.
        ev_start = evt_count;
        exp_q.push_back(4'h3);
        pressed[0*4+3] = 1'b1;
        wait_evt(ev_start);
`ifdef KEYPAD_SCAN_REPEAT_EN
        exp_evts = 4;
        repeat (3) exp_q.push_back(4'h3);
`else
        exp_evts = 1;
`endif
        repeat (50) @(negedge clk);
        pressed = '0;
        repeat (60) @(negedge clk);
        chk("repeat_event_count", 8'(evt_count - ev_start), 8'(exp_evts));

        // Random presses: too short to accept, or long with a ghost key on another row.
        for (int it = 0; it < 14; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                pressed[r*4+c] = 1'b1;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                pressed = '0;
            end else begin
                ev_start = evt_count;
                exp_q.push_back(4'({r[1:0], c[1:0]}));
                pressed[r*4+c] = 1'b1;
                wait_evt(ev_start);
                n = $urandom_range(0, 2);
                d = 16 * n + 3 + $urandom_range(0, 8);
`ifdef KEYPAD_SCAN_REPEAT_EN
                repeat (n) exp_q.push_back(4'({r[1:0], c[1:0]}));
`endif
                gi = ((r + 1 + $urandom_range(0, 2)) % 4) * 4 + $urandom_range(0, 3);
                pressed[gi] = 1'b1;
                repeat (d / 2) @(negedge clk);
                pressed[gi] = 1'b0;
                repeat (d - d / 2) @(negedge clk);
                pressed = '0;
            end
            repeat (40) @(negedge clk);
            chk("txn_idle_key_down", 8'(key_down), 8'd0);
        end

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        chk("overrun_total", 8'(ov_count), 8'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_mux.md
KEYPAD_SCAN_MUX -- requirements
Module: keypad_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 14, prescaler width; one scan tick every 2^SCAN_BITS clk cycles.
REQ-002 SHALL have parameter DEB_TICKS, default 8, consecutive matching ticks required for press/release acceptance.
REQ-003 SHALL have parameter REPEAT_TICKS, default 256, ticks between auto-repeat events (used only when REQ-030 applies).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port col_in  input  4  keypad columns, active-low, asynchronous (pulled up externally).
REQ-007 SHALL have port row_out  output  4  row drive, one-hot active-low.
REQ-008 SHALL have port key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-009 SHALL have port key_valid  output  1  key_code holds an unacknowledged key.
REQ-010 SHALL have port key_ack  input  1  consumer acknowledge, one-cycle pulse.
REQ-011 SHALL have port key_down  output  1  high while an accepted key is held.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when an accepted key is dropped.

Function
REQ-013 SHALL pass col_in through a two-flop synchronizer before any use; this adds 2 cycles of input latency.
REQ-014 SHALL run a free-running SCAN_BITS prescaler; tick asserts for one cycle when the prescaler is all ones, then wraps to 0.
REQ-015 SHALL implement FSM states SCAN, DEBOUNCE, HELD; all FSM decisions occur only on tick cycles.
REQ-016 SCAN: on tick with synchronized columns all high, row index SHALL advance 0->1->2->3->0 and row_out SHALL drive 1110, 1101, 1011, 0111 respectively.
REQ-017 SCAN: on tick with any column low, SHALL capture row index and lowest-index low column, clear the debounce counter, enter DEBOUNCE; row does not advance.
REQ-018 DEBOUNCE: row SHALL stay frozen; each tick with the same column pattern increments the counter, any differing pattern returns to SCAN with the row advanced.
REQ-019 DEBOUNCE: when the counter reaches DEB_TICKS, SHALL accept the key, set key_down, enter HELD.
REQ-020 On acceptance with key_valid low, or with key_ack high in the same cycle, SHALL load key_code and hold key_valid high the next cycle.
REQ-021 On acceptance with key_valid high and key_ack low, SHALL keep the old key_code and pulse overrun for one cycle.
REQ-022 key_ack while key_valid high and no acceptance SHALL clear key_valid next cycle; key_ack while key_valid low SHALL be ignored.
REQ-023 key_code SHALL remain stable while key_valid is high.
REQ-024 HELD: row SHALL stay frozen; after DEB_TICKS consecutive ticks with all columns high, SHALL clear key_down and return to SCAN with the row advanced; any low column restarts that count.
REQ-025 Pressing a second key on another row while in HELD SHALL have no effect.

Reset
REQ-026 When reset is high at a clk edge, SHALL set state SCAN, row index 0, row_out 1110, prescaler 0, all counters 0, synchronizer flops 1111.
REQ-027 Reset SHALL set key_code 0000, key_valid 0, key_down 0, overrun 0, and override any operation in progress, including a pending key_valid.

Configuration
REQ-028 Macro KEYPAD_SCAN_REPEAT_EN SHALL select auto-repeat.
REQ-029 Without the macro, HELD SHALL emit no further events and the repeat counter SHALL not exist.
REQ-030 With the macro, HELD SHALL count ticks with the key still pressed and, every REPEAT_TICKS ticks, issue an acceptance per REQ-020/REQ-021 with the same code; the release count resets the repeat count.

Structure
REQ-031 Shared package keypad_pkg SHALL hold FSM state encodings, row one-hot drive constants, and the default values of SCAN_BITS, DEB_TICKS, REPEAT_TICKS.
REQ-032 The two-flop column synchronizer SHALL be a sub-module named keypad_sync; all other logic SHALL live in keypad_scan_mux.

Verification (SCAN_BITS=2, DEB_TICKS=3, REPEAT_TICKS=4)
REQ-033 Reset, idle columns 1111 -> row_out cycles 1110,1101,1011,0111,1110 with 4-cycle dwell; key_valid stays 0.
REQ-034 Hold col_in=1011 only while row 2 is driven -> freeze on row 2, key_code=1010 and key_valid=1 after 3 matching ticks, key_down=1; ack -> key_valid=0 next cycle.
REQ-035 Bounce col_in 1110/1111 on alternate ticks during DEBOUNCE -> return to SCAN, no key_valid, no overrun.
REQ-036 Accept key 0x5 without ack, then release and accept 0xC -> overrun pulses once, key_code stays 0101; repeat with key_ack on the acceptance cycle -> key_code=1100, key_valid stays 1, no overrun.
REQ-037 Assert reset mid-DEBOUNCE and with key_valid=1 -> next cycle all outputs at reset values, row_out=1110.
REQ-038 With KEYPAD_SCAN_REPEAT_EN, hold key 0x3 for 12 ticks past acceptance, acking each -> 3 extra key_valid events of 0011; without macro -> none.
